// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - Q(P.F) datapath defaults and constants
package fixed_pkg;

    localparam int F_DEFAULT = 10;
    localparam int P_DEFAULT = 5;
    localparam int W_DEFAULT = F_DEFAULT + P_DEFAULT + 1;

    localparam logic [W_DEFAULT-1:0] MAX_POS = {1'b0, {(W_DEFAULT-1){1'b1}}};
    localparam logic [W_DEFAULT-1:0] MAX_NEG = {1'b1, {(W_DEFAULT-1){1'b0}}};

    localparam logic RND_TRUNC  = 1'b0;
    localparam logic RND_HALFUP = 1'b1;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_HIGH = 2'b01,
        SAT_LOW  = 2'b10
    } sat_e;

endpackage

// File: rtl/fx_round_sat.sv
// rtl/fx_round_sat.sv - optional half-up rounding, arithmetic shift and saturation of a 2W-bit value
module fx_round_sat
    import fixed_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int SHIFT = F_DEFAULT
) (
    input  logic signed [2*W-1:0] din,
    input  logic                  rnd,
    output logic signed [W-1:0]   dout,
    output logic                  ovf,
    output logic                  unf
);

    localparam logic signed [2*W-1:0] ONE  = 1;
    // Half an output LSB; evaluates to zero when SHIFT is 0 so the sum path never rounds.
    localparam logic signed [2*W-1:0] HALF = (ONE << SHIFT) >> 1;

    logic signed [2*W-1:0] biased;
    logic signed [2*W-1:0] shifted;
    logic                  in_range;
    sat_e                  sat;

    assign biased   = din + (rnd ? HALF : '0);
    assign shifted  = biased >>> SHIFT;
    assign in_range = (&shifted[2*W-1:W-1]) | ~(|shifted[2*W-1:W-1]);

    always_comb begin
        sat = SAT_NONE;
        if (!in_range) begin
            sat = shifted[2*W-1] ? SAT_LOW : SAT_HIGH;
        end
    end

    always_comb begin
        dout = shifted[W-1:0];
        case (sat)
            SAT_HIGH: dout = {1'b0, {(W-1){1'b1}}};
            SAT_LOW:  dout = {1'b1, {(W-1){1'b0}}};
            default:  dout = shifted[W-1:0];
        endcase
    end

    assign ovf = (sat == SAT_HIGH);
    assign unf = (sat == SAT_LOW);

endmodule

// File: rtl/mult_mac_pipe.sv
// rtl/mult_mac_pipe.sv - two-stage saturating fixed-point multiply/accumulate with valid/ready streams
module mult_mac_pipe
    import fixed_pkg::*;
#(
    parameter  int F = F_DEFAULT,
    parameter  int P = P_DEFAULT,
    localparam int W = F + P + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                in_acc,
    input  logic                in_clr,
    input  logic                rnd_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] y,
    output logic                ovf,
    output logic                unf,
    output logic                sat_sticky,
    input  logic                sticky_clr
);

    logic                  s1_valid;
    logic signed [2*W-1:0] s1_prod;
    logic                  s1_acc;
    logic                  s1_clr;
    logic                  s1_rnd;
    logic                  s1_load;
    logic                  s1_advance;

    logic signed [W-1:0]   acc;
    logic signed [2*W-1:0] prod_full;
    logic signed [W-1:0]   prod_sat;
    logic                  p_ovf;
    logic                  p_unf;
    logic signed [W-1:0]   base;
    logic signed [W:0]     sum;
    logic signed [2*W-1:0] sum_ext;
    logic signed [W-1:0]   acc_next;
    logic                  s_ovf;
    logic                  s_unf;
    logic signed [W-1:0]   res_y;
    logic                  res_ovf;
    logic                  res_unf;

    // S1 drains whenever the output slot is empty or being consumed this cycle.
    assign s1_advance = s1_valid & (~out_valid | out_ready);
    assign in_ready   = ~s1_valid | s1_advance;
    assign s1_load    = in_valid & in_ready;

    assign prod_full = (2*W)'(a) * (2*W)'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_acc   <= 1'b0;
            s1_clr   <= 1'b0;
            s1_rnd   <= RND_TRUNC;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_prod <= prod_full;
                s1_acc  <= in_acc;
                s1_clr  <= in_clr;
                s1_rnd  <= rnd_mode;
            end
        end
    end

    fx_round_sat #(.W(W), .SHIFT(F)) u_prod_sat (
        .din  (s1_prod),
        .rnd  (s1_rnd),
        .dout (prod_sat),
        .ovf  (p_ovf),
        .unf  (p_unf)
    );

    assign base    = s1_clr ? '0 : acc;
    assign sum     = {base[W-1], base} + {prod_sat[W-1], prod_sat};
    assign sum_ext = {{(W-1){sum[W]}}, sum};

    fx_round_sat #(.W(W), .SHIFT(0)) u_sum_sat (
        .din  (sum_ext),
        .rnd  (1'b0),
        .dout (acc_next),
        .ovf  (s_ovf),
        .unf  (s_unf)
    );

    always_comb begin
        res_y   = prod_sat;
        res_ovf = p_ovf;
        res_unf = p_unf;
        if (s1_acc) begin
            res_y   = acc_next;
            res_ovf = p_ovf | s_ovf;
            res_unf = p_unf | s_unf;
        end
    end

    // Output register and accumulator both update only on the S1->S2 transfer, so a stalled beat
    // is never folded into the accumulator twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (s1_advance) begin
                out_valid <= 1'b1;
                y         <= res_y;
                ovf       <= res_ovf;
                unf       <= res_unf;
                if (s1_acc) begin
                    acc <= acc_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (sticky_clr) begin
            sat_sticky <= 1'b0;
        end else if (s1_advance & (res_ovf | res_unf)) begin
            sat_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_mac_pipe.sv
// tb/tb_mult_mac_pipe.sv - self-checking bench for mult_mac_pipe
module tb_mult_mac_pipe;
    import fixed_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               in_acc;
    logic               in_clr;
    logic               rnd_mode;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] y;
    logic               ovf;
    logic               unf;
    logic               sat_sticky;
    logic               sticky_clr;

    int n_checks = 0;
    int n_fail   = 0;

    mult_mac_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .in_acc     (in_acc),
        .in_clr     (in_clr),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .ovf        (ovf),
        .unf        (unf),
        .sat_sticky (sat_sticky),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vacc;
        logic        vclr;
        logic        vrnd;
        logic [15:0] ey;
        logic        eovf;
        logic        eunf;
    } vec_t;

    typedef struct {
        logic [15:0] ry;
        logic        rovf;
        logic        runf;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting on handshake", name);
    endtask

    function automatic int sat_w(input longint v, output bit o, output bit u);
        o = 0;
        u = 0;
        if (v > 32767) begin
            o = 1;
            return 32767;
        end
        if (v < -32768) begin
            u = 1;
            return -32768;
        end
        return int'(v);
    endfunction

    // Reference: exact product, optional +half LSB, floor divide by 2^10, clamp; then accumulate and clamp.
    function automatic res_t ref_beat(input logic signed [15:0] ra, input logic signed [15:0] rb,
                                      input bit racc, input bit rclr, input bit rrnd, inout int acc_m);
        res_t   r;
        longint p;
        longint q;
        int     m;
        int     s;
        bit     o1, u1, o2, u2;
        p = longint'(ra) * longint'(rb);
        if (rrnd) p = p + 512;
        q = p >>> 10;
        m = sat_w(q, o1, u1);
        o2 = 0;
        u2 = 0;
        if (racc) begin
            s = sat_w(longint'(rclr ? 0 : acc_m) + longint'(m), o2, u2);
            acc_m = s;
            m = s;
        end
        r.ry   = 16'(m);
        r.rovf = o1 | o2;
        r.runf = u1 | u2;
        return r;
    endfunction

    task automatic do_beat(input logic [15:0] ta, input logic [15:0] tb_v, input logic tacc,
                           input logic tclr, input logic trnd,
                           output logic [15:0] gy, output logic go, output logic gu, output int lat);
        bit ok;
        int n;
        @(posedge clk); #1;
        a = ta; b = tb_v; in_acc = tacc; in_clr = tclr; rnd_mode = trnd;
        in_valid = 1'b1; out_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
            n++;
        end
        gy = y; go = ovf; gu = unf;
        if (!ok || lat < 0) report_timeout("beat");
    endtask

    vec_t        vt[13];
    res_t        expq[$];
    res_t        er;
    logic [15:0] gy;
    logic        go, gu;
    int          lat;
    logic        st_exp;
    int          macc;
    int          k, got, acc_cnt;
    logic [15:0] first_y;
    bit          have_y, prev_stall, took;
    logic [15:0] prev_y;
    logic        prev_o, prev_u;

    initial begin
        vt[0]  = '{16'h0800, 16'h0C00, 0, 0, RND_TRUNC,  16'h1800, 0, 0};
        vt[1]  = '{16'h5000, 16'h5000, 0, 0, RND_TRUNC,  MAX_POS,  1, 0};
        vt[2]  = '{16'hB000, 16'h5000, 0, 0, RND_TRUNC,  MAX_NEG,  0, 1};
        vt[3]  = '{16'h0001, 16'h0200, 0, 0, RND_TRUNC,  16'h0000, 0, 0};
        vt[4]  = '{16'h0001, 16'h0200, 0, 0, RND_HALFUP, 16'h0001, 0, 0};
        vt[5]  = '{16'hFFFF, 16'h0200, 0, 0, RND_TRUNC,  16'hFFFF, 0, 0};
        vt[6]  = '{16'hFFFF, 16'h0200, 0, 0, RND_HALFUP, 16'h0000, 0, 0};
        vt[7]  = '{16'h0400, 16'h0400, 1, 1, RND_TRUNC,  16'h0400, 0, 0};
        vt[8]  = '{16'h0400, 16'h0400, 1, 0, RND_TRUNC,  16'h0800, 0, 0};
        vt[9]  = '{16'h0800, 16'h0800, 0, 0, RND_TRUNC,  16'h1000, 0, 0};
        vt[10] = '{16'h0400, 16'h0400, 1, 0, RND_TRUNC,  16'h0C00, 0, 0};
        vt[11] = '{16'h1400, 16'h1800, 1, 1, RND_TRUNC,  16'h7800, 0, 0};
        vt[12] = '{16'h4000, 16'h0400, 1, 0, RND_TRUNC,  MAX_POS,  1, 0};

        rst_n = 1'b0; in_valid = 0; a = 0; b = 0; in_acc = 0; in_clr = 0;
        rnd_mode = 0; out_ready = 1; sticky_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_y", 32'(y), 0);
        check("rst_ovf_unf", {30'd0, ovf, unf}, 0);
        check("rst_sticky", 32'(sat_sticky), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        st_exp = 0;
        for (int i = 0; i < 13; i++) begin
            do_beat(vt[i].va, vt[i].vb, vt[i].vacc, vt[i].vclr, vt[i].vrnd, gy, go, gu, lat);
            check($sformatf("vec%0d_y", i), 32'(gy), 32'(vt[i].ey));
            check($sformatf("vec%0d_flags", i), {30'd0, go, gu}, {30'd0, vt[i].eovf, vt[i].eunf});
            check($sformatf("vec%0d_latency", i), 32'(lat), 2);
            st_exp = st_exp | vt[i].eovf | vt[i].eunf;
            check($sformatf("vec%0d_sticky", i), 32'(sat_sticky), 32'(st_exp));
            if (i == 2) begin
                @(posedge clk); #1 sticky_clr = 1'b1;
                @(posedge clk); #1 sticky_clr = 1'b0;
                @(negedge clk);
                st_exp = 0;
                check("sticky_clr", 32'(sat_sticky), 0);
            end
        end

        // Clear held across a saturating result: the set is lost and stays lost.
        sticky_clr = 1'b1;
        do_beat(16'h5000, 16'h5000, 0, 0, RND_TRUNC, gy, go, gu, lat);
        check("clrwins_ovf", 32'(go), 1);
        check("clrwins_sticky", 32'(sat_sticky), 0);
        @(posedge clk); #1 sticky_clr = 1'b0;
        @(negedge clk);
        check("clrwins_after", 32'(sat_sticky), 0);

        // Backpressure: 4 distinct beats against a blocked consumer.
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; in_acc = 0; in_clr = 0; rnd_mode = 0;
        k = 0; acc_cnt = 0; have_y = 0;
        a = 16'h0400; b = 16'h0400;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (out_valid && !have_y) begin
                first_y = y;
                have_y = 1;
            end
            @(posedge clk); #1;
            if (took) begin
                acc_cnt++;
                k++;
                a = 16'(16'h0400 * (k + 1));
            end
        end
        @(negedge clk);
        check("bp_accepted", 32'(acc_cnt), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_y_stable", 32'(y), 32'(first_y));
        check("bp_y_first", 32'(y), 32'h0400);
        @(posedge clk); #1;
        out_ready = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("bp_res%0d", got), 32'(y), 32'(16'h0400 * (got + 1)));
                got++;
            end
            @(posedge clk); #1;
            if (took) begin
                k++;
                a = 16'(16'h0400 * (k + 1));
                if (k >= 4) in_valid = 0;
            end
        end
        check("bp_all_out", 32'(got), 4);

        // Reset with two accumulate beats in flight.
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; in_acc = 1; in_clr = 1; a = 16'h1400; b = 16'h0400;
        @(posedge clk); #1;
        in_clr = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        check("inflight_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_y", 32'(y), 0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1;
        do_beat(16'h0400, 16'h0400, 1, 0, RND_TRUNC, gy, go, gu, lat);
        check("post_rst_acc", 32'(gy), 32'h0400);

        // Randomised traffic against the reference model.
        macc = 32'sh0400;
        prev_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            b         = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            in_acc    = 1'($urandom_range(0, 1));
            in_clr    = ($urandom_range(0, 3) == 0);
            rnd_mode  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_hold", {13'd0, y, ovf, unf}, {13'd0, prev_y, prev_o, prev_u});
            end
            if (in_valid && in_ready)
                expq.push_back(ref_beat(a, b, in_acc, in_clr, rnd_mode, macc));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    report_timeout("rand_unexpected_output");
                end else begin
                    er = expq.pop_front();
                    check("rand_result", {13'd0, y, ovf, unf}, {13'd0, er.ry, er.rovf, er.runf});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y = y; prev_o = ovf; prev_u = unf;
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && expq.size() != 0) begin
                er = expq.pop_front();
                check("drain_result", {13'd0, y, ovf, unf}, {13'd0, er.ry, er.rovf, er.runf});
            end
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
